// File: rtl/btb_predictor.sv
// -----------------------------------------------------------------------------
// btb_predictor
//
// Direct-mapped branch target buffer with per-entry saturating counters.
// The fetch-side lookup is purely combinational. Resolved branches update the
// table on the rising edge of clk.
//
// Optional feature (compile-time macro):
//   BP_GSHARE_EN : the counters move into their own 2**IDX_W table, which is
//                  indexed by (pc index XOR global history register). The ghr
//                  shifts in upd_taken on every update. Valid, tag and target
//                  stay indexed by the raw pc bits.
//
// Parameters:
//   WORD_SIZE : PC/target width in bits
//   IDX_W     : index bits, table depth 2**IDX_W (1 <= IDX_W < WORD_SIZE)
//   CNT_W     : saturating counter width (>= 2)
//
// Ports:
//   clk        in   clock, all state changes on its rising edge
//   reset_n    in   asynchronous active-low reset
//   pc         in   fetch lookup address
//   next_pc    out  predicted next fetch address
//   pred_hit   out  lookup found a valid entry with a matching tag
//   pred_taken out  predicted taken (next_pc is the stored target)
//   upd_valid  in   resolved-branch update strobe
//   upd_pc     in   resolved branch address
//   upd_taken  in   resolved outcome, 1 = taken
//   upd_target in   resolved taken target
// -----------------------------------------------------------------------------
module btb_predictor #(
   parameter int WORD_SIZE = 16,
   parameter int IDX_W     = 8,
   parameter int CNT_W     = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WORD_SIZE-1:0] pc,
   output logic [WORD_SIZE-1:0] next_pc,
   output logic                 pred_hit,
   output logic                 pred_taken,
   input  logic                 upd_valid,
   input  logic [WORD_SIZE-1:0] upd_pc,
   input  logic                 upd_taken,
   input  logic [WORD_SIZE-1:0] upd_target
);

   localparam int DEPTH = 1 << IDX_W;
   localparam int TAG_W = WORD_SIZE - IDX_W;

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t CNT_MAX    = {CNT_W{1'b1}};
   localparam cnt_t CNT_ZERO   = {CNT_W{1'b0}};
   localparam cnt_t CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam cnt_t WEAK_TAKEN = {1'b1, {(CNT_W-1){1'b0}}};
   localparam cnt_t WEAK_NT    = {1'b0, {(CNT_W-1){1'b1}}};

   localparam logic [WORD_SIZE-1:0] PC_INC = {{(WORD_SIZE-1){1'b0}}, 1'b1};

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [DEPTH-1:0]            valid_q,  valid_d;
   logic [DEPTH-1:0][CNT_W-1:0] cnt_q,    cnt_d;
   logic [TAG_W-1:0]            tag_q    [DEPTH];
   logic [TAG_W-1:0]            tag_d    [DEPTH];
   logic [WORD_SIZE-1:0]        target_q [DEPTH];
   logic [WORD_SIZE-1:0]        target_d [DEPTH];

`ifdef BP_GSHARE_EN
   logic [IDX_W-1:0]            ghr_q,    ghr_d;
`endif

   // ---------------------------------------------------------------------------
   // Address split
   // ---------------------------------------------------------------------------
   logic [IDX_W-1:0] lk_idx,  lk_cidx;
   logic [TAG_W-1:0] lk_tag;
   logic [IDX_W-1:0] upd_idx, upd_cidx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit;
   cnt_t             upd_cnt;

   assign lk_idx  = pc[IDX_W-1:0];
   assign lk_tag  = pc[WORD_SIZE-1:IDX_W];
   assign upd_idx = upd_pc[IDX_W-1:0];
   assign upd_tag = upd_pc[WORD_SIZE-1:IDX_W];

`ifdef BP_GSHARE_EN
   // Both sides hash with the current (pre-update) history.
   assign lk_cidx  = lk_idx  ^ ghr_q;
   assign upd_cidx = upd_idx ^ ghr_q;
`else
   assign lk_cidx  = lk_idx;
   assign upd_cidx = upd_idx;
`endif

   // ---------------------------------------------------------------------------
   // Lookup: combinational and reads only the registered state. A lookup that
   // coincides with an update to the same index therefore sees the old contents.
   // ---------------------------------------------------------------------------
   always_comb begin
      pred_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_taken = pred_hit && cnt_q[lk_cidx][CNT_W-1];
      next_pc    = pred_taken ? target_q[lk_idx] : (pc + PC_INC);
   end

   // ---------------------------------------------------------------------------
   // Update next-state
   // ---------------------------------------------------------------------------
   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   assign upd_cnt = cnt_q[upd_cidx];

   // NOTE: every *_d gets its hold value first, so each path through the block
   // assigns it and no latch is inferred.
   always_comb begin
      valid_d  = valid_q;
      cnt_d    = cnt_q;
      tag_d    = tag_q;
      target_d = target_q;
`ifdef BP_GSHARE_EN
      ghr_d    = ghr_q;
`endif

      if (upd_valid) begin
         if (upd_hit) begin
            if (upd_taken) begin
               target_d[upd_idx] = upd_target;
               if (upd_cnt != CNT_MAX) begin
                  cnt_d[upd_cidx] = upd_cnt + CNT_ONE;
               end
            end else if (upd_cnt != CNT_ZERO) begin
               cnt_d[upd_cidx] = upd_cnt - CNT_ONE;
            end
         end else if (upd_taken) begin
            // Allocate on a taken miss. A not-taken miss leaves no trace.
            valid_d[upd_idx]  = 1'b1;
            tag_d[upd_idx]    = upd_tag;
            target_d[upd_idx] = upd_target;
            cnt_d[upd_cidx]   = WEAK_TAKEN;
         end
`ifdef BP_GSHARE_EN
         // Shift left and insert the outcome at bit 0. The cast keeps the low
         // IDX_W bits, which also covers IDX_W == 1.
         ghr_d = IDX_W'({ghr_q, upd_taken});
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: only valid bits, counters and history need a reset value. Tag and
   // target are never read while their entry is invalid, so they are left as
   // plain storage without reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         cnt_q   <= {DEPTH{WEAK_NT}};
`ifdef BP_GSHARE_EN
         ghr_q   <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments, so every register samples the
         // pre-edge value of its next-state logic.
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
`ifdef BP_GSHARE_EN
         ghr_q   <= ghr_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      tag_q    <= tag_d;
      target_q <= target_d;
   end

endmodule

// File: tb/tb_btb_predictor.sv
// -----------------------------------------------------------------------------
// tb_btb_predictor
//
// Directed bench for btb_predictor (WORD_SIZE=16, IDX_W=8, CNT_W=2). The steps
// run in order in one initial block. Each step's expected outputs are worked
// out by hand from the counter and table behaviour of the predictor.
// -----------------------------------------------------------------------------
module tb_btb_predictor;

   logic        clk;
   logic        reset_n;
   logic [15:0] pc;
   logic [15:0] next_pc;
   logic        pred_hit;
   logic        pred_taken;
   logic        upd_valid;
   logic [15:0] upd_pc;
   logic        upd_taken;
   logic [15:0] upd_target;

   int n_vec;
   int n_err;

   btb_predictor #(
      .WORD_SIZE(16),
      .IDX_W    (8),
      .CNT_W    (2)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .pc        (pc),
      .next_pc   (next_pc),
      .pred_hit  (pred_hit),
      .pred_taken(pred_taken),
      .upd_valid (upd_valid),
      .upd_pc    (upd_pc),
      .upd_taken (upd_taken),
      .upd_target(upd_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   // One update cycle. Inputs are applied just after a rising edge and
   // removed just after the edge that consumes them.
   task automatic upd(input logic [15:0] a, input logic t, input logic [15:0] tgt);
      upd_valid  = 1'b1;
      upd_pc     = a;
      upd_taken  = t;
      upd_target = tgt;
      @(posedge clk);
      #1;
      upd_valid  = 1'b0;
      upd_pc     = '0;
      upd_taken  = 1'b0;
      upd_target = '0;
   endtask

   task automatic look(input logic [15:0] a);
      pc = a;
      #1;
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      reset_n    = 1'b0;
      pc         = 16'h0012;
      upd_valid  = 1'b0;
      upd_pc     = '0;
      upd_taken  = 1'b0;
      upd_target = '0;

      // Outputs while reset is held
      #2;
      check("rst_hold_hit",   pred_hit,   16'h0000);
      check("rst_hold_taken", pred_taken, 16'h0000);
      check("rst_hold_next",  next_pc,    16'h0013);

      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      // First cycle after reset
      check("post_rst_hit",   pred_hit,   16'h0000);
      check("post_rst_taken", pred_taken, 16'h0000);
      check("post_rst_next",  next_pc,    16'h0013);

`ifdef BP_GSHARE_EN
      // Allocation writes hashed counter 0x12 (ghr was 0). The ghr becomes
      // 0x01, so the lookup reads counter 0x13, which is still weakly not-taken.
      upd(16'h0012, 1'b1, 16'h0040);
      look(16'h0012);
      check("gs_hit",   pred_hit,   16'h0001);
      check("gs_taken", pred_taken, 16'h0000);
      check("gs_next",  next_pc,    16'h0013);
      // A taken update at 0x12 hits. It bumps counter 0x13 to weakly taken and
      // shifts the ghr to 0x03, so the lookup now reads counter 0x11 (weakly
      // not-taken).
      upd(16'h0012, 1'b1, 16'h0040);
      look(16'h0012);
      check("gs_hit2",   pred_hit,   16'h0001);
      check("gs_taken2", pred_taken, 16'h0000);
`else
      // Taken allocation at 0x0012. The lookup in the same cycle still misses.
      pc         = 16'h0012;
      upd_valid  = 1'b1;
      upd_pc     = 16'h0012;
      upd_taken  = 1'b1;
      upd_target = 16'h0040;
      #1;
      check("same_cycle_hit", pred_hit, 16'h0000);
      check("same_cycle_next", next_pc, 16'h0013);
      @(posedge clk);
      #1;
      upd_valid  = 1'b0;
      #1;
      // Counter is now weakly taken (2)
      check("alloc_hit",   pred_hit,   16'h0001);
      check("alloc_taken", pred_taken, 16'h0001);
      check("alloc_next",  next_pc,    16'h0040);

      // Same index with a different tag
      look(16'h0112);
      check("alias_hit",  pred_hit, 16'h0000);
      check("alias_next", next_pc,  16'h0113);

      // Counter goes 2 -> 3 -> 3 (saturates), then 3 -> 2
      upd(16'h0012, 1'b1, 16'h0040);
      upd(16'h0012, 1'b1, 16'h0040);
      upd(16'h0012, 1'b0, 16'h0000);
      look(16'h0012);
      check("nt1_taken", pred_taken, 16'h0001);
      // 2 -> 1
      upd(16'h0012, 1'b0, 16'h0000);
      look(16'h0012);
      check("nt2_hit",   pred_hit,   16'h0001);
      check("nt2_taken", pred_taken, 16'h0000);
      check("nt2_next",  next_pc,    16'h0013);

      // 1 -> 0 -> 0 (saturates at zero), then 0 -> 1 (still not taken)
      upd(16'h0012, 1'b0, 16'h0000);
      upd(16'h0012, 1'b0, 16'h0000);
      upd(16'h0012, 1'b1, 16'h0080);
      look(16'h0012);
      check("sat0_taken", pred_taken, 16'h0000);
      // 1 -> 2 with the target replaced by 0x0080
      upd(16'h0012, 1'b1, 16'h0080);
      look(16'h0012);
      check("retarget_taken", pred_taken, 16'h0001);
      check("retarget_next",  next_pc,    16'h0080);

      // A not-taken miss changes nothing
      upd(16'h0112, 1'b0, 16'h0300);
      look(16'h0012);
      check("ntmiss_keep_hit",  pred_hit, 16'h0001);
      check("ntmiss_keep_next", next_pc,  16'h0080);
      look(16'h0112);
      check("ntmiss_no_alloc", pred_hit, 16'h0000);

      // An update with upd_valid low is ignored (it would otherwise drop the
      // counter to 1)
      upd_pc    = 16'h0012;
      upd_taken = 1'b0;
      @(posedge clk);
      #1;
      upd_pc    = '0;
      look(16'h0012);
      check("no_valid_taken", pred_taken, 16'h0001);

      // A taken miss replaces the entry with a weakly taken one
      upd(16'h0112, 1'b1, 16'h0200);
      look(16'h0112);
      check("replace_hit",   pred_hit,   16'h0001);
      check("replace_taken", pred_taken, 16'h0001);
      check("replace_next",  next_pc,    16'h0200);
      look(16'h0012);
      check("evicted_hit",  pred_hit, 16'h0000);
      check("evicted_next", next_pc,  16'h0013);

      // pc+1 wraps around
      look(16'hFFFF);
      check("wrap_next", next_pc, 16'h0000);

      // Asynchronous reset between clock edges
      look(16'h0112);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("async_rst_hit",  pred_hit, 16'h0000);
      check("async_rst_next", next_pc,  16'h0113);
      look(16'hFFFF);
      check("async_rst_wrap", next_pc, 16'h0000);

      // An update presented while reset is held is dropped
      upd(16'h0012, 1'b1, 16'h0040);
      @(negedge clk);
      reset_n = 1'b1;
      look(16'h0012);
      check("rst_upd_drop_hit",  pred_hit, 16'h0000);
      check("rst_upd_drop_next", next_pc,  16'h0013);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, PC/target width in bits.
REQ-002 SHALL have parameter IDX_W, default 8, index bits; table depth 2**IDX_W entries; 1 <= IDX_W < WORD_SIZE.
REQ-003 SHALL have parameter CNT_W, default 2, per-entry saturating counter width; CNT_W >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port pc  input  WORD_SIZE  fetch-stage lookup address.
REQ-007 SHALL have port next_pc  output  WORD_SIZE  predicted next fetch address.
REQ-008 SHALL have port pred_hit  output  1  lookup hit a valid entry with matching tag.
REQ-009 SHALL have port pred_taken  output  1  prediction is taken; next_pc is the stored target.
REQ-010 SHALL have port upd_valid  input  1  resolved-branch update strobe, one update per asserted cycle.
REQ-011 SHALL have port upd_pc  input  WORD_SIZE  address of the resolved branch.
REQ-012 SHALL have port upd_taken  input  1  resolved outcome, 1 = taken.
REQ-013 SHALL have port upd_target  input  WORD_SIZE  resolved taken target.

Function
REQ-014 Index = pc[IDX_W-1:0], tag = pc[WORD_SIZE-1:IDX_W]; each entry SHALL hold valid, tag, target and a CNT_W-bit counter.
REQ-015 Lookup SHALL be combinational, zero-cycle latency: pred_hit = valid & tag match.
REQ-016 pred_taken SHALL equal pred_hit & counter MSB.
REQ-017 next_pc SHALL be target when pred_taken, else pc+1 modulo 2**WORD_SIZE (0xFFFF -> 0x0000).
REQ-018 On a rising edge with upd_valid=1 and a valid, tag-matching entry, the counter SHALL increment on taken, saturating at all-ones, and decrement on not-taken, saturating at zero.
REQ-019 On such a hit with upd_taken=1, the target SHALL be overwritten with upd_target.
REQ-020 On an update miss with upd_taken=1, the entry SHALL be replaced: valid=1, new tag, target=upd_target, counter = weakly taken (MSB 1, others 0).
REQ-021 On an update miss with upd_taken=0, no state SHALL change.
REQ-022 A lookup and an update to the same index in the same cycle SHALL return pre-update contents; new contents are visible from the next cycle.
REQ-023 upd_valid=0 SHALL leave all state unchanged.

Reset
REQ-024 reset_n=0 SHALL immediately, without a clock, clear all valid bits, set every counter to weakly not-taken (MSB 0, others 1) and clear the history register.
REQ-025 During reset and in the first cycle after it, outputs SHALL be pred_hit=0, pred_taken=0, next_pc=pc+1.
REQ-026 An update coincident with reset assertion SHALL be discarded.

Configuration
REQ-027 With macro BP_GSHARE_EN defined, counters SHALL be held in a separate 2**IDX_W table. Lookup indexes it by pc[IDX_W-1:0] XOR ghr. Updates index it by upd_pc[IDX_W-1:0] XOR ghr, using the pre-update ghr.
REQ-028 With BP_GSHARE_EN defined, the IDX_W-bit ghr SHALL shift left, inserting upd_taken at bit 0, on every update.
REQ-029 With BP_GSHARE_EN defined, tag/target/valid SHALL still be indexed by pc bits, and the REQ-020 allocation SHALL set the hashed counter entry to weakly taken.
REQ-030 Without BP_GSHARE_EN, there SHALL be no ghr, and counters SHALL be per-entry as in REQ-014 to REQ-021.

Verification (WORD_SIZE=16, IDX_W=8, CNT_W=2, macro undefined unless stated)
REQ-031 After reset, pc=0x0012 -> pred_hit=0, pred_taken=0, next_pc=0x0013.
REQ-032 Update upd_pc=0x0012, taken, target 0x0040, then pc=0x0012 -> pred_hit=1, pred_taken=1, next_pc=0x0040.
REQ-033 After REQ-032, pc=0x0112 (same index, other tag) -> pred_hit=0, next_pc=0x0113.
REQ-034 After REQ-032: two taken updates, then two not-taken updates. After the first not-taken, pred_taken=1. After the second, pred_hit=1, pred_taken=0, next_pc=0x0013.
REQ-035 Drop reset_n between clock edges after REQ-032 -> pred_hit=0 immediately, no clock edge. pc=0xFFFF -> next_pc=0x0000.
REQ-036 With BP_GSHARE_EN: update 0x0012 taken to 0x0040 (ghr becomes 0x01), then pc=0x0012 -> pred_hit=1, pred_taken=0 (hashed index 0x13 is still weakly not-taken).
